// File: rtl/sram_1r1w_masked_if.sv
// Read/write port bundle for sram_1r1w_masked: one read port (R0) and one
// masked write port (W0), both sampled on the shared clock.
interface sram_1r1w_masked_if #(
   parameter int AW    = 11,
   parameter int WIDTH = 16,
   parameter int MASKW = 8
);
   logic             R0_en;
   logic [AW-1:0]    R0_addr;
   logic [WIDTH-1:0] R0_data;
   logic             W0_en;
   logic [AW-1:0]    W0_addr;
   logic [MASKW-1:0] W0_mask;
   logic [WIDTH-1:0] W0_data;

   modport master (
      output R0_en, R0_addr, W0_en, W0_addr, W0_mask, W0_data,
      input  R0_data
   );

   modport slave (
      input  R0_en, R0_addr, W0_en, W0_addr, W0_mask, W0_data,
      output R0_data
   );
endinterface

// File: rtl/sram_1r1w_masked.sv
// Behavioural 1R1W SRAM with lane-masked writes, a post-reset zeroing sweep,
// optional same-address write-to-read bypass and a held registered read port.
module sram_1r1w_masked #(
   parameter int DEPTH  = 2048,
   parameter int WIDTH  = 16,
   parameter int GRAN   = 2,
   parameter int BYPASS = 1,
   localparam int MASKW = WIDTH / GRAN,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                clock,
   input  logic                reset_n,
   output logic                init_done,
   sram_1r1w_masked_if.slave   bus
);

   typedef enum logic {INIT, RUN} state_t;

   localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t           state_q, state_d;
   logic [AW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [WIDTH-1:0] rd_word;
   logic [WIDTH-1:0] lane_bits;
   logic             rd_in_range;
   logic             wr_in_range;
   logic             collide;

   // Expand the per-lane mask into a per-bit mask.
   always_comb begin
      lane_bits = '0;
      for (int i = 0; i < MASKW; i++) begin
         lane_bits[i*GRAN +: GRAN] = {GRAN{bus.W0_mask[i]}};
      end
   end

   assign rd_in_range = {1'b0, bus.R0_addr} < DEPTH_EXT;
   assign wr_in_range = {1'b0, bus.W0_addr} < DEPTH_EXT;
   assign collide     = bus.W0_en && wr_in_range && (bus.W0_addr == bus.R0_addr);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INIT;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // The sweep leaves INIT on the same edge that clears the last entry.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         INIT: begin
            count_d = count_q + 1'b1;
            if (count_q == LAST_ADDR) begin
               state_d = RUN;
               count_d = '0;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = INIT;
            count_d = '0;
         end
      endcase
   end

   // Storage has no reset; only the sweep zeroes it.
   always_ff @(posedge clock) begin
      if (state_q == INIT) begin
         mem[count_q] <= '0;
      end else if (bus.W0_en && wr_in_range) begin
         mem[bus.W0_addr] <= (mem[bus.W0_addr] & ~lane_bits) | (bus.W0_data & lane_bits);
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      rd_word = '0;
      if (state_q == RUN && bus.R0_en) begin
         if (rd_in_range) begin
            rd_word = mem[bus.R0_addr];
            if (BYPASS != 0 && collide) begin
               rd_word = (rd_word & ~lane_bits) | (bus.W0_data & lane_bits);
            end
         end
         rdata_d = rd_word;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign bus.R0_data = rdata_q;
   assign init_done   = (state_q == RUN);

endmodule

// File: tb/tb_sram_1r1w_masked.sv
// Bench for sram_1r1w_masked: a DEPTH=16 bypass build and a DEPTH=12
// non-bypass build share stimulus and are checked against an array model.
module tb_sram_1r1w_masked;

   localparam int AW = 4;
   localparam int W  = 16;
   localparam int MW = 8;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic init_a, init_b;

   logic          r_en   = 1'b0;
   logic          w_en   = 1'b0;
   logic [AW-1:0] r_addr = '0;
   logic [AW-1:0] w_addr = '0;
   logic [MW-1:0] w_mask = '0;
   logic [W-1:0]  w_data = '0;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state, index 0 = build A (DEPTH 16, bypass), 1 = build B (DEPTH 12, no bypass)
   int          depth [2] = '{16, 12};
   bit          byp   [2] = '{1'b1, 1'b0};
   logic [15:0] m_mem [2][16];
   int          m_cnt [2];
   bit          m_run [2];
   logic [15:0] m_rd  [2];

   sram_1r1w_masked_if #(.AW(AW), .WIDTH(W), .MASKW(MW)) bus_a ();
   sram_1r1w_masked_if #(.AW(AW), .WIDTH(W), .MASKW(MW)) bus_b ();

   assign bus_a.R0_en   = r_en;
   assign bus_a.R0_addr = r_addr;
   assign bus_a.W0_en   = w_en;
   assign bus_a.W0_addr = w_addr;
   assign bus_a.W0_mask = w_mask;
   assign bus_a.W0_data = w_data;
   assign bus_b.R0_en   = r_en;
   assign bus_b.R0_addr = r_addr;
   assign bus_b.W0_en   = w_en;
   assign bus_b.W0_addr = w_addr;
   assign bus_b.W0_mask = w_mask;
   assign bus_b.W0_data = w_data;

   sram_1r1w_masked #(.DEPTH(16), .WIDTH(16), .GRAN(2), .BYPASS(1)) dut_a (
      .clock(clock), .reset_n(reset_n), .init_done(init_a), .bus(bus_a)
   );

   sram_1r1w_masked #(.DEPTH(12), .WIDTH(16), .GRAN(2), .BYPASS(0)) dut_b (
      .clock(clock), .reset_n(reset_n), .init_done(init_b), .bus(bus_b)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] expand(input logic [7:0] m);
      logic [15:0] b;
      for (int i = 0; i < 8; i++) b[2*i +: 2] = {2{m[i]}};
      return b;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = 0;
         m_run[d] = 1'b0;
         m_rd[d]  = 16'h0000;
      end
   endtask

   // Expected state after the coming edge, from the inputs applied before it.
   task automatic model_update();
      logic [15:0] bm, v;
      bm = expand(w_mask);
      for (int d = 0; d < 2; d++) begin
         if (!m_run[d]) begin
            m_mem[d][m_cnt[d]] = 16'h0000;
            m_cnt[d]++;
            if (m_cnt[d] == depth[d]) m_run[d] = 1'b1;
         end else begin
            if (r_en) begin
               if (int'(r_addr) < depth[d]) begin
                  v = m_mem[d][r_addr];
                  if (byp[d] && w_en && w_addr == r_addr) v = (v & ~bm) | (w_data & bm);
                  m_rd[d] = v;
               end else begin
                  m_rd[d] = 16'h0000;
               end
            end
            if (w_en && int'(w_addr) < depth[d])
               m_mem[d][w_addr] = (m_mem[d][w_addr] & ~bm) | (w_data & bm);
         end
      end
   endtask

   task automatic checkOutput();
      check("A_rdata", bus_a.R0_data, m_rd[0]);
      check("A_init",  {15'b0, init_a}, {15'b0, m_run[0]});
      check("B_rdata", bus_b.R0_data, m_rd[1]);
      check("B_init",  {15'b0, init_b}, {15'b0, m_run[1]});
   endtask

   task automatic applyStimulus(input logic re, input logic [3:0] ra, input logic we,
                                input logic [3:0] wa, input logic [7:0] wm, input logic [15:0] wd);
      r_en = re; r_addr = ra; w_en = we; w_addr = wa; w_mask = wm; w_data = wd;
      model_update();
      @(posedge clock);
      #1;
      checkOutput();
   endtask

   task automatic idle();
      applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 16'h0000);
   endtask

   // Asserts reset away from a clock edge and expects outputs to drop at once.
   task automatic assert_reset(input string tag);
      reset_n = 1'b0;
      #1;
      check({tag, "_A_rdata_async"}, bus_a.R0_data, 16'h0000);
      check({tag, "_A_init_async"},  {15'b0, init_a}, 16'h0000);
      check({tag, "_B_rdata_async"}, bus_b.R0_data, 16'h0000);
      check({tag, "_B_init_async"},  {15'b0, init_b}, 16'h0000);
      model_reset();
      @(posedge clock);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic full_sweep(input string tag);
      for (int k = 1; k <= 16; k++) begin
         idle();
         check({tag, "_A_sweep_edge"}, {15'b0, init_a}, (k >= 16) ? 16'h1 : 16'h0);
         check({tag, "_B_sweep_edge"}, {15'b0, init_b}, (k >= 12) ? 16'h1 : 16'h0);
      end
   endtask

   initial begin
      model_reset();
      #2;
      check("reset_A_rdata", bus_a.R0_data, 16'h0000);
      check("reset_A_init",  {15'b0, init_a}, 16'h0000);
      check("reset_B_rdata", bus_b.R0_data, 16'h0000);
      check("reset_B_init",  {15'b0, init_b}, 16'h0000);
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      full_sweep("first");

      for (int a = 0; a < 16; a++) begin
         applyStimulus(1'b1, 4'(a), 1'b0, 4'd0, 8'h00, 16'h0000);
         check("zero_A", bus_a.R0_data, 16'h0000);
         check("zero_B", bus_b.R0_data, 16'h0000);
      end

      applyStimulus(1'b0, 4'd0, 1'b1, 4'd5, 8'hFF, 16'hFFFF);
      applyStimulus(1'b0, 4'd0, 1'b1, 4'd5, 8'h0F, 16'h0000);
      applyStimulus(1'b1, 4'd5, 1'b0, 4'd0, 8'h00, 16'h0000);
      check("masked_A", bus_a.R0_data, 16'hFF00);
      check("masked_B", bus_b.R0_data, 16'hFF00);

      applyStimulus(1'b0, 4'd0, 1'b1, 4'd3, 8'hFF, 16'h1234);
      applyStimulus(1'b1, 4'd3, 1'b1, 4'd3, 8'hF0, 16'hABCD);
      check("collide_A_bypass", bus_a.R0_data, 16'hAB34);
      check("collide_B_old",    bus_b.R0_data, 16'h1234);
      applyStimulus(1'b1, 4'd3, 1'b0, 4'd0, 8'h00, 16'h0000);
      check("collide_A_after", bus_a.R0_data, 16'hAB34);
      check("collide_B_after", bus_b.R0_data, 16'hAB34);

      applyStimulus(1'b0, 4'd0, 1'b1, 4'd7, 8'hFF, 16'h00AA);
      applyStimulus(1'b1, 4'd7, 1'b0, 4'd0, 8'h00, 16'h0000);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 4'd0, 1'b1, 4'd7, 8'hFF, 16'h5555);
         check("hold_A", bus_a.R0_data, 16'h00AA);
         check("hold_B", bus_b.R0_data, 16'h00AA);
      end
      applyStimulus(1'b1, 4'd7, 1'b0, 4'd0, 8'h00, 16'h0000);
      check("hold_A_next", bus_a.R0_data, 16'h5555);
      check("hold_B_next", bus_b.R0_data, 16'h5555);

      assert_reset("run");
      for (int k = 0; k < 9; k++) idle();
      assert_reset("sweep9");
      full_sweep("resweep");

      applyStimulus(1'b0, 4'd0, 1'b1, 4'd13, 8'hFF, 16'hFFFF);
      applyStimulus(1'b1, 4'd13, 1'b0, 4'd0, 8'h00, 16'h0000);
      check("oor_B_read", bus_b.R0_data, 16'h0000);
      check("inrange_A_read", bus_a.R0_data, 16'hFFFF);
      for (int a = 0; a < 12; a++) begin
         applyStimulus(1'b1, 4'(a), 1'b0, 4'd0, 8'h00, 16'h0000);
         check("oor_B_intact", bus_b.R0_data, 16'h0000);
      end

      for (int k = 0; k < 600; k++) begin
         logic          re, we;
         logic [3:0]    ra, wa;
         logic [7:0]    wm;
         re = ($urandom_range(0, 3) != 0);
         we = ($urandom_range(0, 1) != 0);
         ra = 4'($urandom);
         wa = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom);
         wm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         applyStimulus(re, ra, we, wa, wm, 16'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
